// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO_DEPTH-word queue feeding a serialiser with
// configurable data width, parity, stop bits and a forced idle gap between frames.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int GAP_CYC    = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        clr_ovf,
    output logic                        TX,
    output logic                        busy,
    output logic                        tx_done,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int TMR_MAX  = (BAUD_DIV > GAP_CYC) ? BAUD_DIV : GAP_CYC;
    localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int BIT_W    = 4;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push, pop;

    state_t            state, state_d;
    logic [TMR_W-1:0]  tmr, tmr_d;
    logic [BIT_W-1:0]  bit_idx, bit_d;
    logic [DATA_W-1:0] shift, shift_d;
    logic              par_bit, par_d;
    logic              tx_d, done_d, load, baud_end;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    // A full queue still accepts a write on the edge that pops its head.
    assign push  = wr_en && (!full || pop);
    assign pop   = load;
    assign busy  = (state != S_IDLE);

    // NOTE: the word storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            // A fresh overflow outranks a clear in the same cycle.
            if (wr_en && full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        // NOTE: every signal of this block is defaulted first so no path infers a latch.
        state_d  = state;
        tmr_d    = tmr + TMR_W'(1);
        bit_d    = bit_idx;
        shift_d  = shift;
        par_d    = par_bit;
        tx_d     = TX;
        done_d   = 1'b0;
        load     = 1'b0;
        baud_end = (tmr == TMR_W'(BAUD_DIV - 1));

        case (state)
            S_IDLE: begin
                tmr_d = '0;
                tx_d  = 1'b1;
                if (!empty) load = 1'b1;
            end
            S_START: begin
                if (baud_end) begin
                    tmr_d   = '0;
                    tx_d    = shift[0];
                    shift_d = shift >> 1;
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    tmr_d = '0;
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = par_bit;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        tx_d    = shift[0];
                        shift_d = shift >> 1;
                        bit_d   = bit_idx + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    tmr_d   = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    tmr_d = '0;
                    if (bit_idx == BIT_W'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        if (GAP_CYC > 0) begin
                            state_d = S_GAP;
                        end else if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_idx + BIT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (tmr == TMR_W'(GAP_LAST)) begin
                    tmr_d = '0;
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase

        // Popping the head always launches a start bit on the same edge.
        if (load) begin
            shift_d = mem[rd_ptr];
            par_d   = (^mem[rd_ptr]) ^ (PARITY_ODD != 0);
            tx_d    = 1'b0;
            tmr_d   = '0;
            bit_d   = '0;
            state_d = S_START;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tmr     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            TX      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_d;
            tmr     <= tmr_d;
            bit_idx <= bit_d;
            shift   <= shift_d;
            par_bit <= par_d;
            TX      <= tx_d;
            tx_done <= done_d;
        end
    end

endmodule
